// File: rtl/vga_fb_writer_if.sv
// Pixel-stream and burst-write signals between the frame-buffer writer and its neighbours.
// The master side is the writer; the slave side is the pixel source plus drv_ssram.
interface vga_fb_writer_if;
    logic        frame_start;
    logic        pixel_valid;
    logic [11:0] pixel_rgb;
    logic        pixel_ready;
    logic        frame_done;
    logic        burst_write_request;
    logic [29:0] burst_write_address;
    logic        burst_write_ready;
    logic [35:0] burst_write_data;

    modport master (
        input  frame_start, pixel_valid, pixel_rgb, burst_write_ready,
        output pixel_ready, frame_done, burst_write_request, burst_write_address, burst_write_data
    );

    modport slave (
        output frame_start, pixel_valid, pixel_rgb, burst_write_ready,
        input  pixel_ready, frame_done, burst_write_request, burst_write_address, burst_write_data
    );
endinterface

// File: rtl/vga_fb_writer.sv
// Packs RGB444 pixels three per word into a ping-pong line buffer and writes
// one SSRAM burst per line into the video frame buffer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for the drain bank to become full
// S_BURST   | request high, presenting word[rd_idx] until word 213 is taken
// S_ADVANCE | one cycle: step address / line count, pulse frame_done at frame end
module vga_fb_writer #(
    parameter int          LINES         = 256,
    parameter logic [29:0] FB_BASE_DIV_4 = 30'h04060000,
    parameter logic [29:0] LINE_STRIDE   = 30'd216
) (
    input  logic           clk_30,
    input  logic           reset_n,
    vga_fb_writer_if.master bus
);
    localparam int             WORDS     = 214;
    localparam logic [7:0]     LAST_WORD = 8'd213;
    localparam int             LCW       = $clog2(LINES + 1);
    localparam logic [LCW-1:0] LINE_LAST = LCW'(LINES - 1);
    localparam logic [LCW-1:0] LINE_END  = LCW'(LINES);
    localparam logic [LCW-1:0] ONE_L     = LCW'(1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_ADVANCE} state_t;
    state_t state, state_nx;

    logic [35:0]    line_mem [0:1][0:WORDS-1];
    logic [1:0]     phase;
    logic [7:0]     wr_idx;
    logic           fill_bank;
    logic [23:0]    acc;
    logic [1:0]     bank_full;
    logic [LCW-1:0] lines_in;
    logic [7:0]     rd_idx;
    logic           drain_bank;
    logic [LCW-1:0] line_cnt;
    logic [29:0]    address;
    logic           fs_pend;

    logic        in_drop, pix_take, line_end, commit;
    logic [1:0]  ph_eff;
    logic [7:0]  wi_eff;
    logic [35:0] commit_word;
    logic [1:0]  fill_set, drain_clr, keep_mask;
    logic        drain_done, advance, frame_done_c;

    // A pixel arriving with frame_start is pixel 0 of line 0, even in the drop window.
    assign in_drop        = (lines_in == LINE_END);
    assign bus.pixel_ready = in_drop || (bank_full != 2'b11);
    assign pix_take       = bus.pixel_valid && bus.pixel_ready && (!in_drop || bus.frame_start);
    assign ph_eff         = bus.frame_start ? 2'd0 : phase;
    assign wi_eff         = bus.frame_start ? 8'd0 : wr_idx;
    assign line_end       = pix_take && (wi_eff == LAST_WORD) && (ph_eff == 2'd0);
    assign commit         = pix_take && ((ph_eff == 2'd2) || line_end);
    assign commit_word    = line_end ? {bus.pixel_rgb, 24'h0} : {acc, bus.pixel_rgb};
    assign fill_set       = line_end ? (2'b01 << fill_bank) : 2'b00;
    assign drain_clr      = drain_done ? (2'b01 << drain_bank) : 2'b00;
    assign keep_mask      = (state == S_BURST) ? (2'b01 << drain_bank) : 2'b00;

    always_ff @(posedge clk_30) begin
        if (commit) line_mem[fill_bank][wi_eff] <= commit_word;
    end

    always_ff @(posedge clk_30 or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= 2'd0;
            wr_idx    <= 8'd0;
            fill_bank <= 1'b0;
            acc       <= 24'h0;
            bank_full <= 2'b00;
            lines_in  <= '0;
        end else begin
            // frame_start discards any full bank that is not currently draining
            if (bus.frame_start) begin
                bank_full <= bank_full & ~drain_clr & keep_mask;
                fill_bank <= (state == S_BURST) ? ~drain_bank : drain_bank;
                lines_in  <= '0;
            end else begin
                bank_full <= (bank_full & ~drain_clr) | fill_set;
                if (line_end) begin
                    fill_bank <= ~fill_bank;
                    lines_in  <= lines_in + ONE_L;
                end
            end
            if (pix_take) begin
                if (line_end || ph_eff == 2'd2) begin
                    phase  <= 2'd0;
                    wr_idx <= line_end ? 8'd0 : wi_eff + 8'd1;
                end else begin
                    phase  <= ph_eff + 2'd1;
                    wr_idx <= wi_eff;
                end
                if (ph_eff == 2'd0) acc[23:12] <= bus.pixel_rgb;
                if (ph_eff == 2'd1) acc[11:0]  <= bus.pixel_rgb;
            end else if (bus.frame_start) begin
                phase  <= 2'd0;
                wr_idx <= 8'd0;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        drain_done   = 1'b0;
        advance      = 1'b0;
        frame_done_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (bank_full[drain_bank] && !bus.frame_start) state_nx = S_BURST;
            end
            S_BURST: begin
                if (bus.burst_write_ready && rd_idx == LAST_WORD) begin
                    drain_done = 1'b1;
                    state_nx   = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                advance      = 1'b1;
                frame_done_c = !fs_pend && !bus.frame_start && (line_cnt == LINE_LAST);
                state_nx     = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_30 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rd_idx     <= 8'd0;
            drain_bank <= 1'b0;
            line_cnt   <= '0;
            address    <= FB_BASE_DIV_4;
            fs_pend    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_BURST && bus.burst_write_ready)
                rd_idx <= drain_done ? 8'd0 : rd_idx + 8'd1;
            if (drain_done) drain_bank <= ~drain_bank;
            if (advance)
                fs_pend <= 1'b0;
            else if (bus.frame_start && state == S_BURST)
                fs_pend <= 1'b1;
            // a new frame or the end of the current one both rewind to the base
            if (advance) begin
                if (fs_pend || bus.frame_start || line_cnt == LINE_LAST) begin
                    address  <= FB_BASE_DIV_4;
                    line_cnt <= '0;
                end else begin
                    address  <= address + LINE_STRIDE;
                    line_cnt <= line_cnt + ONE_L;
                end
            end else if (state == S_IDLE && bus.frame_start) begin
                address  <= FB_BASE_DIV_4;
                line_cnt <= '0;
            end
        end
    end

    assign bus.frame_done          = frame_done_c;
    assign bus.burst_write_request = (state == S_BURST);
    assign bus.burst_write_address = address;
    assign bus.burst_write_data    = (state == S_BURST) ? line_mem[drain_bank][rd_idx] : 36'h0;
endmodule
